// File: rtl/vga_config_master.sv
// VGA configuration bus initiator: turns resolution requests into
// acknowledged config writes, with timeout, retry and redundant-write skip.
module vga_config_master #(
  parameter int                    CONFIG_WIDTH   = 8,
  parameter logic [CONFIG_WIDTH-1:0] VGA_CFG_ADDR = 8'h01,
  parameter int                    TIMEOUT_CYCLES = 16,
  parameter int                    MAX_RETRIES    = 3,
  parameter int                    TO_WIDTH       = 5
) (
  input  logic                    Clk,
  input  logic                    rst_n,
  input  logic                    Req_valid,
  output logic                    Req_ready,
  input  logic [1:0]              Req_res,
  input  logic                    Req_force,
  output logic                    C_valid,
  output logic [CONFIG_WIDTH-1:0] C_addr,
  output logic [CONFIG_WIDTH-1:0] C_data,
  input  logic                    C_rdy,
  output logic                    Done,
  output logic                    Err,
  output logic                    Busy,
  output logic [1:0]              Cur_res
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SEND   = 3'd1;
  localparam logic [2:0] S_WAIT   = 3'd2;
  localparam logic [2:0] S_FINISH = 3'd3;
  localparam logic [2:0] S_FAIL   = 3'd4;

  localparam int RW =
    (MAX_RETRIES < 2) ? 1 : $clog2(MAX_RETRIES + 1);

  logic [2:0]              r_state;
  logic [1:0]              r_res;
  logic [1:0]              r_cur;
  logic [RW-1:0]           r_retry;
  logic [TO_WIDTH-1:0]     r_to;
  logic                    r_ready;
  logic                    r_valid;
  logic [CONFIG_WIDTH-1:0] r_addr;
  logic [CONFIG_WIDTH-1:0] r_data;
  logic                    r_done;
  logic                    r_err;
  logic                    r_busy;

  logic [2:0] w_next;
  logic [1:0] w_res;
  logic       w_accept;
  logic       w_to;
  logic       w_can_retry;
  logic       w_send;

  assign w_accept    = (r_state == S_IDLE) && Req_valid && r_ready;
  assign w_to        = (r_to == TO_WIDTH'(TIMEOUT_CYCLES - 1));
  assign w_can_retry = (r_retry < RW'(MAX_RETRIES));
  assign w_res       = w_accept ? Req_res : r_res;
  assign w_send      = (w_next == S_SEND);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (Req_res == 2'b11)
            w_next = S_FAIL;
          else if ((Req_res == r_cur) && !Req_force)
            w_next = S_FINISH;
          else
            w_next = S_SEND;
        end
      end
      S_SEND: w_next = S_WAIT;
      S_WAIT: begin
        // An ack landing on the timeout cycle still counts.
        if (C_rdy)
          w_next = S_FINISH;
        else if (w_to)
          w_next = w_can_retry ? S_SEND : S_FAIL;
      end
      S_FINISH: w_next = S_IDLE;
      S_FAIL:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_res   <= 2'b00;
      r_cur   <= 2'b00;
      r_retry <= '0;
      r_to    <= '0;
      r_ready <= 1'b0;
      r_valid <= 1'b0;
      r_addr  <= '0;
      r_data  <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_ready <= (w_next == S_IDLE);
      r_busy  <= (w_next != S_IDLE);
      r_done  <= (w_next == S_FINISH);
      r_err   <= (w_next == S_FAIL);
      r_valid <= w_send;
      r_addr  <= w_send ? VGA_CFG_ADDR : '0;
      r_data  <= w_send ? CONFIG_WIDTH'(w_res) : '0;
      if (w_accept) begin
        r_res   <= Req_res;
        r_retry <= '0;
      end
      if (r_state == S_SEND)
        r_to <= '0;
      if (r_state == S_WAIT) begin
        if (C_rdy)
          r_cur <= r_res;
        else if (!w_to)
          r_to <= r_to + 1'b1;
        else if (w_can_retry)
          r_retry <= r_retry + 1'b1;
      end
    end
  end

  assign Req_ready = r_ready;
  assign C_valid   = r_valid;
  assign C_addr    = r_addr;
  assign C_data    = r_data;
  assign Done      = r_done;
  assign Err       = r_err;
  assign Busy      = r_busy;
  assign Cur_res   = r_cur;

endmodule

// File: tb/tb_vga_config_master.sv
// Bench for vga_config_master: vector table driven through a
// scoreboard, with a registered responder and reset corner cases.
module tb_vga_config_master;

  localparam int CW = 8;

  logic          Clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          Req_valid = 1'b0;
  logic          Req_ready;
  logic [1:0]    Req_res = 2'b00;
  logic          Req_force = 1'b0;
  logic          C_valid;
  logic [CW-1:0] C_addr;
  logic [CW-1:0] C_data;
  logic          C_rdy;
  logic          Done;
  logic          Err;
  logic          Busy;
  logic [1:0]    Cur_res;

  logic resp_rdy = 1'b0;
  logic force_rdy = 1'b0;
  assign C_rdy = resp_rdy | force_rdy;

  vga_config_master dut (
    .Clk(Clk), .rst_n(rst_n),
    .Req_valid(Req_valid), .Req_ready(Req_ready),
    .Req_res(Req_res), .Req_force(Req_force),
    .C_valid(C_valid), .C_addr(C_addr), .C_data(C_data),
    .C_rdy(C_rdy), .Done(Done), .Err(Err),
    .Busy(Busy), .Cur_res(Cur_res)
  );

  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  // Registered responder: acks attempt number ack_att of the request.
  int vcount = 0;
  int base = 0;
  int ack_att = 0;
  always @(posedge Clk) begin
    if (C_valid) begin
      vcount   <= vcount + 1;
      resp_rdy <= ((vcount - base + 1) == ack_att);
    end else begin
      resp_rdy <= 1'b0;
    end
  end

  typedef struct {
    logic [1:0] res;
    logic       frc;
    int         ack;
    int         nw;
    logic       err;
    logic [1:0] cur;
    int         lat;
  } vec_t;

  typedef struct {
    logic       err;
    logic [1:0] cur;
    int         lat;
    int         nw;
  } res_t;

  vec_t          vt[10];
  res_t          rq[$];
  logic [CW-1:0] wq[$];

  int total = 0;
  int bad = 0;
  int acc_cyc = 0;
  int wseen = 0;
  int last_v = 0;
  int nres = 0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    res_t          r;
    logic [CW-1:0] d;
    @(negedge Clk);
    if (rst_n) begin
      if (C_valid) begin
        if (wseen > 0) chk("retry_spacing", cyc - last_v, 17);
        wseen++;
        last_v = cyc;
        if (wq.size() == 0) begin
          chk("unexpected_write", 1, 0);
        end else begin
          d = wq.pop_front();
          chk("c_addr", int'(C_addr), 1);
          chk("c_data", int'(C_data), int'(d));
        end
      end
      if (Done && Err) chk("done_and_err", 1, 0);
      if (Done || Err) begin
        nres++;
        if (rq.size() == 0) begin
          chk("unexpected_result", 1, 0);
        end else begin
          r = rq.pop_front();
          chk("err_flag", int'(Err), int'(r.err));
          chk("cur_res", int'(Cur_res), int'(r.cur));
          chk("latency", cyc - acc_cyc, r.lat);
          chk("n_writes", wseen, r.nw);
          chk("busy_at_result", int'(Busy), 1);
        end
      end
    end
  endtask

  task automatic start_req(input vec_t v);
    int n;
    n = 0;
    while (!Req_ready && n < 50) begin
      tick();
      n++;
    end
    if (!Req_ready) chk("ready_timeout", 0, 1);
    base    = vcount;
    ack_att = v.ack;
    wseen   = 0;
    repeat (v.nw) wq.push_back({6'b0, v.res});
    rq.push_back('{v.err, v.cur, v.lat, v.nw});
    Req_valid = 1'b1;
    Req_res   = v.res;
    Req_force = v.frc;
    acc_cyc   = cyc;
    tick();
    Req_valid = 1'b0;
    Req_force = 1'b0;
    chk("ready_while_busy", int'(Req_ready), 0);
  endtask

  task automatic run(input vec_t v);
    int n;
    int n0;
    n0 = nres;
    start_req(v);
    n = 0;
    while (nres == n0 && n < 200) begin
      tick();
      n++;
    end
    if (nres == n0) chk("result_timeout", 0, 1);
    tick();
    chk("busy_after", int'(Busy), 0);
    chk("ready_after", int'(Req_ready), 1);
  endtask

  task automatic chk_reset_vals();
    chk("rst_ready", int'(Req_ready), 0);
    chk("rst_cvalid", int'(C_valid), 0);
    chk("rst_caddr", int'(C_addr), 0);
    chk("rst_cdata", int'(C_data), 0);
    chk("rst_done", int'(Done), 0);
    chk("rst_err", int'(Err), 0);
    chk("rst_busy", int'(Busy), 0);
    chk("rst_cur", int'(Cur_res), 0);
  endtask

  initial begin
    int n;
    vec_t v;
    vt[0] = '{2'b00, 1'b0, 0, 0, 1'b0, 2'b00, 1};
    vt[1] = '{2'b00, 1'b1, 1, 1, 1'b0, 2'b00, 3};
    vt[2] = '{2'b01, 1'b0, 1, 1, 1'b0, 2'b01, 3};
    vt[3] = '{2'b01, 1'b0, 1, 0, 1'b0, 2'b01, 1};
    vt[4] = '{2'b11, 1'b0, 0, 0, 1'b1, 2'b01, 1};
    vt[5] = '{2'b11, 1'b1, 0, 0, 1'b1, 2'b01, 1};
    vt[6] = '{2'b10, 1'b0, 0, 4, 1'b1, 2'b01, 69};
    vt[7] = '{2'b10, 1'b0, 3, 3, 1'b0, 2'b10, 37};
    vt[8] = '{2'b00, 1'b0, 2, 2, 1'b0, 2'b00, 20};
    vt[9] = '{2'b10, 1'b1, 4, 4, 1'b0, 2'b10, 54};

    force_rdy = 1'b1;
    repeat (3) tick();
    chk_reset_vals();
    rst_n = 1'b1;
    tick();
    force_rdy = 1'b0;
    chk("post_rst_ready", int'(Req_ready), 1);
    chk("post_rst_done", int'(Done), 0);
    chk("post_rst_err", int'(Err), 0);
    chk("post_rst_cur", int'(Cur_res), 0);
    tick();
    chk("post_rst_done2", int'(Done), 0);
    chk("post_rst_busy", int'(Busy), 0);

    for (int i = 0; i < 10; i++) run(vt[i]);

    v = '{2'b01, 1'b0, 3, 3, 1'b0, 2'b01, 37};
    start_req(v);
    n = 0;
    while (wseen < 2 && n < 100) begin
      tick();
      n++;
    end
    chk("second_attempt_seen", wseen, 2);
    repeat (5) tick();
    chk("mid_busy", int'(Busy), 1);
    rst_n = 1'b0;
    #1;
    chk_reset_vals();
    wq.delete();
    rq.delete();
    ack_att = 0;
    repeat (2) tick();
    chk("held_rst_cvalid", int'(C_valid), 0);
    rst_n = 1'b1;
    tick();
    chk("rerst_ready", int'(Req_ready), 1);
    chk("rerst_cur", int'(Cur_res), 0);

    v = '{2'b00, 1'b0, 0, 0, 1'b0, 2'b00, 1};
    run(v);
    repeat (3) tick();
    chk("wq_empty", wq.size(), 0);
    chk("rq_empty", rq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=%0d expected=0", cyc);
    $fatal(1, "timeout");
  end

endmodule
